// File: rtl/u_add_pkg.sv
// Shared types and limits for the wrap-checking adder controller.
package u_add_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 4;
  localparam int LAT_MAX   = 15;
  localparam int CNT_W     = 8;
  localparam int WAIT_W    = $clog2(LAT_MAX + 1);
endpackage

// File: rtl/u_add_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module u_add_sat_cnt
  import u_add_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/u_add_wo_carry.sv
// Downstream adder: one registered stage, carry-out dropped.
module u_add_wo_carry #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic [WIDTH-1:0] o_Z
);
  logic [WIDTH-1:0] r_z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_z <= '0;
    else
      r_z <= i_A + i_B;
  end

  assign o_Z = r_z;
endmodule

// File: rtl/u_add_wrap_ctrl.sv
// Sequences one add through an external adder and flags lost carry / mismatch.
module u_add_wrap_ctrl
  import u_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [WIDTH-1:0]  i_A,
  input  logic [WIDTH-1:0]  i_B,
  output logic [WIDTH-1:0]  o_A,
  output logic [WIDTH-1:0]  o_B,
  input  logic [WIDTH-1:0]  i_Z,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [WIDTH-1:0]  o_sum,
  output logic              o_wrap,
  output logic              o_err,
  input  logic              i_clr,
  output logic [CNT_W-1:0]  o_wrap_cnt
);
  localparam logic [WAIT_W-1:0] LAT_V = WAIT_W'(LAT);
  localparam logic [WIDTH:0]    MASK  = {1'b0, {WIDTH{1'b1}}};

  state_t            r_state;
  logic              r_ready;
  logic              r_valid;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_sum;
  logic              r_wrap;
  logic              r_err;
  logic [WAIT_W-1:0] r_wait;

  logic [WIDTH:0] w_z_ext;
  logic [WIDTH:0] w_a_ext;
  logic [WIDTH:0] w_ab;
  logic           w_wrap;
  logic           w_err;
  logic           w_inc;

  // Compare in WIDTH+1 bits so nothing is truncated before the test.
  assign w_z_ext = {1'b0, i_Z};
  assign w_a_ext = {1'b0, r_a};
  assign w_ab    = {1'b0, r_a} + {1'b0, r_b};
  assign w_wrap  = w_z_ext < w_a_ext;
  assign w_err   = w_z_ext != (w_ab & MASK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
      r_wait  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (i_valid && r_ready) begin
            r_a     <= i_A;
            r_b     <= i_B;
            r_wait  <= LAT_V;
            r_ready <= 1'b0;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (r_wait == '0) begin
            r_sum   <= i_Z;
            r_wrap  <= w_wrap;
            r_err   <= w_err;
            r_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        DONE: begin
          if (r_valid && i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign w_inc = r_valid && i_ready && r_wrap;

  u_add_sat_cnt #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (i_clr),
    .i_inc (w_inc),
    .o_cnt (o_wrap_cnt)
  );

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_A     = r_a;
  assign o_B     = r_b;
  assign o_sum   = r_sum;
  assign o_wrap  = r_wrap;
  assign o_err   = r_err;
endmodule

// File: doc/u_add_wrap_ctrl.md
U_ADD_WRAP_CTRL -- requirements
Module: u_add_wrap_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand, sum and result width in bits.
REQ-002 SHALL have parameter LAT, default 1, legal range 1..15: clock edges from operand drive to i_Z sampling, matching the downstream adder.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port i_valid, input, 1: upstream operand pair valid.
REQ-006 SHALL have port o_ready, output, 1: block accepts an operand pair.
REQ-007 SHALL have ports i_A and i_B, input, WIDTH each: upstream operands.
REQ-008 SHALL have ports o_A and o_B, output, WIDTH each: operands driven to the adder.
REQ-009 SHALL have port i_Z, input, WIDTH: adder result, modulo 2^WIDTH.
REQ-010 SHALL have port o_valid, output, 1: result valid.
REQ-011 SHALL have port i_ready, input, 1: downstream accepts the result.
REQ-012 SHALL have port o_sum, output, WIDTH: captured i_Z.
REQ-013 SHALL have port o_wrap, output, 1: carry lost, meaning captured sum < captured A, unsigned.
REQ-014 SHALL have port o_err, output, 1: captured sum differs from locally computed (A+B) mod 2^WIDTH.
REQ-015 SHALL have port i_clr, input, 1: synchronous clear of the wrap counter.
REQ-016 SHALL have port o_wrap_cnt, output, 8: saturating count of delivered results with o_wrap=1.

Function
REQ-017 SHALL use the FSM states IDLE, EXEC and DONE.
REQ-018 In IDLE, o_ready SHALL be 1; in EXEC and DONE, o_ready SHALL be 0.
REQ-019 In IDLE, when i_valid and o_ready are both 1 at an edge, the block SHALL latch i_A and i_B into operand registers and go to EXEC, loading its wait counter with LAT.
REQ-020 o_A and o_B SHALL always drive the operand registers, holding the last latched pair while in IDLE.
REQ-021 In EXEC, the wait counter SHALL decrement each edge; at the edge where it reaches 0, the block SHALL capture i_Z into o_sum, compute o_wrap and o_err, and go to DONE.
REQ-022 o_valid SHALL be 1 only in DONE and SHALL first rise LAT+1 edges after the accept edge.
REQ-023 In DONE, o_sum, o_wrap and o_err SHALL hold stable until o_valid and i_ready are both 1 at an edge, after which the FSM SHALL return to IDLE.
REQ-024 Throughput SHALL be at most one operation per LAT+2 cycles.
REQ-025 i_valid outside IDLE SHALL be ignored, with no buffering.
REQ-026 o_wrap_cnt SHALL increment by 1 on each edge where o_valid, i_ready and o_wrap are all 1, and SHALL saturate at 255 (no wrap-around).
REQ-027 On an edge where i_clr is 1, o_wrap_cnt SHALL become 0; i_clr SHALL win over a simultaneous increment.
REQ-028 o_wrap and o_err SHALL be computed on WIDTH+1-bit intermediates with no truncation before the comparison.

Reset
REQ-029 While rst_n is 0, the block SHALL hold state IDLE, o_ready 0, o_valid 0, o_A/o_B/o_sum 0, o_wrap 0, o_err 0, o_wrap_cnt 0 and wait counter 0.
REQ-030 o_ready SHALL go to 1 on the first edge after rst_n deasserts.
REQ-031 Reset asserted during EXEC or DONE SHALL discard the in-flight operation, which SHALL never be presented on o_valid.

Structure
REQ-032 A shared package u_add_pkg SHALL hold the state typedef (IDLE/EXEC/DONE), the default WIDTH, LAT_MAX=15 and the counter width of 8.
REQ-033 The saturating, clearable counter SHALL be a sub-module u_add_sat_cnt; everything else SHALL be flat.

Verification
REQ-034 The bench SHALL use WIDTH=4, LAT=1 and the real u_add_wo_carry as the adder, and SHALL cover the following six scenarios.
REQ-035 Reset scenario: rst_n low for 3 edges with i_valid=1 -> all outputs 0 and o_ready 0; first edge after release -> o_ready 1.
REQ-036 Basic-add scenario: A=0011, B=0100 accepted at edge k -> o_valid rises after edge k+2, o_sum=0111, o_wrap=0, o_err=0, o_wrap_cnt unchanged.
REQ-037 Wrap scenario: A=1111, B=0100 -> o_sum=0011, o_wrap=1; after the handshake, o_wrap_cnt increments by 1. Also A=1110, B=0001 -> o_sum=1111, o_wrap=0.
REQ-038 Backpressure scenario: i_ready=0 for 5 cycles in DONE while i_valid pulses with new operands -> o_sum/o_wrap stable, o_ready 0, new operands ignored; i_ready=1 -> IDLE next edge.
REQ-039 Error and saturation scenario: bench forces i_Z=0000 for A=0111, B=0001 -> o_sum=0000, o_err=1. Then 256 wrapping operations -> o_wrap_cnt=255 and no rollover; i_clr=1 coincident with a wrap handshake -> 0.
REQ-040 Mid-operation-reset scenario: rst_n low during EXEC -> o_valid never rises for that operation; the next operation, A=0001, B=0001 -> o_sum=0010.
